ct_writer: RTL

CT_WRITER -- requirements
Module: ct_writer

---
 rtl/ct_writer_pkg.sv | 27 ++
 rtl/ct_writer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ct_writer_pkg.sv
// ct_writer_pkg: shared definitions for the ciphertext writer.
//   - state_t   : FSM state encoding (StZero only when CT_WRITER_ZERO_FILL_EN is defined)
//   - LEN_ADDR  : address of the length byte in both memories
//   - MEM_DEPTH : bytes per memory
//   - LAST_IDX  : highest byte index, used as the end-of-memory compare
package ct_writer_pkg;

    localparam logic [7:0]  LEN_ADDR  = 8'd0;
    localparam int unsigned MEM_DEPTH = 256;
    localparam logic [8:0]  LAST_IDX  = 9'(MEM_DEPTH - 1);

    typedef enum logic [3:0] {
        StIdle,
        StLenRd,
        StLenWait,
        StLenWr,
        StPtRd,
        StPtWait,
        StKs,
        StCtWr
`ifdef CT_WRITER_ZERO_FILL_EN
        ,
        StZero
`endif
    } state_t;

endpackage

// File: rtl/ct_writer.sv
// ct_writer: reads a length-prefixed plaintext message from a synchronous ROM, XORs
// each byte with one keystream byte (valid/ready handshake) and writes the result to
// the ciphertext memory. The length byte at address 0 is copied unencrypted.
//
// Build option: define CT_WRITER_ZERO_FILL_EN to zero ct addresses L+1..255 after
// the last byte (skipped when L=255).
//
// Ports:
//   clk        in   clock, all state changes on posedge
//   rst_n      in   asynchronous active-low reset
//   en         in   start request, only sampled while rdy=1
//   rdy        out  idle and able to accept en
//   pt_addr    out  plaintext ROM address
//   pt_rddata  in   plaintext data, valid one cycle after pt_addr
//   ks_valid   in   keystream byte available
//   ks_ready   out  block accepts keystream byte
//   ks_data    in   keystream byte
//   ct_addr    out  ciphertext write address
//   ct_wrdata  out  ciphertext write data
//   ct_wren    out  ciphertext write strobe
module ct_writer
    import ct_writer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] pt_addr,
    input  logic [7:0] pt_rddata,
    input  logic       ks_valid,
    output logic       ks_ready,
    input  logic [7:0] ks_data,
    output logic [7:0] ct_addr,
    output logic [7:0] ct_wrdata,
    output logic       ct_wren
);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_len,   w_len_nxt;
    logic [8:0] r_idx,   w_idx_nxt;   // 9 bits so index L+1 after byte 255 cannot alias 0
    logic [7:0] r_data,  w_data_nxt;  // plaintext byte, then ciphertext after the handshake

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_len   <= 8'd0;
            r_idx   <= 9'd0;
            r_data  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        rdy         = 1'b0;
        pt_addr     = 8'd0;
        ks_ready    = 1'b0;
        ct_addr     = 8'd0;
        ct_wrdata   = 8'd0;
        ct_wren     = 1'b0;

        unique case (r_state)
            StIdle: begin
                rdy = 1'b1;
                if (en) begin
                    w_state_nxt = StLenRd;
                end
            end
            StLenRd: begin
                pt_addr     = LEN_ADDR;
                w_state_nxt = StLenWait;
            end
            StLenWait: begin
                w_len_nxt   = pt_rddata;
                w_state_nxt = StLenWr;
            end
            StLenWr: begin
                ct_wren   = 1'b1;
                ct_addr   = LEN_ADDR;
                ct_wrdata = r_len;
                w_idx_nxt = 9'd1;
                if (r_len == 8'd0) begin
`ifdef CT_WRITER_ZERO_FILL_EN
                    w_state_nxt = StZero;
`else
                    w_state_nxt = StIdle;
`endif
                end else begin
                    w_state_nxt = StPtRd;
                end
            end
            StPtRd: begin
                pt_addr     = r_idx[7:0];
                w_state_nxt = StPtWait;
            end
            StPtWait: begin
                w_data_nxt  = pt_rddata;
                w_state_nxt = StKs;
            end
            StKs: begin
                ks_ready = 1'b1;
                if (ks_valid) begin
                    w_data_nxt  = r_data ^ ks_data;
                    w_state_nxt = StCtWr;
                end
            end
            StCtWr: begin
                ct_wren   = 1'b1;
                ct_addr   = r_idx[7:0];
                ct_wrdata = r_data;
                w_idx_nxt = r_idx + 9'd1;
                if (r_idx == {1'b0, r_len}) begin
`ifdef CT_WRITER_ZERO_FILL_EN
                    w_state_nxt = (r_idx == LAST_IDX) ? StIdle : StZero;
`else
                    w_state_nxt = StIdle;
`endif
                end else begin
                    w_state_nxt = StPtRd;
                end
            end
`ifdef CT_WRITER_ZERO_FILL_EN
            StZero: begin
                ct_wren   = 1'b1;
                ct_addr   = r_idx[7:0];
                ct_wrdata = 8'd0;
                w_idx_nxt = r_idx + 9'd1;
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = StIdle;
                end
            end
`endif
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

endmodule
